node_id_allocator: RTL
======================

Name: node_id_allocator

Overview:
- Consumes candidate IDs from random_id_generator (valid/ready) and announces each candidate to the router's packet path.
- Listens for a conflict report over a fixed window and commits the ID if no collision is reported; otherwise it retries.
- Sits directly downstream of random_id_generator in packet_controller/router and feeds the node's committed ID to the header builder.

Parameters:
- ID_WIDTH, 8, width of a node ID.
- TIMEOUT_CYCLES, 64, listen-window length in cycles (must be ≥1).
- MAX_RETRY, 7, number of collision retries allowed before declaring failure.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  pulse; begins allocation from IDLE or FAIL.
- rand_valid_i  in  1  candidate ID available.
- rand_id_i  in  ID_WIDTH  candidate ID.
- rand_ready_o  out  1  allocator accepts a candidate this cycle.
- announce_valid_o  out  1  announce request to the packet path.
- announce_id_o  out  ID_WIDTH  ID being announced.
- announce_ready_i  in  1  packet path accepts the announce.
- conflict_valid_i  in  1  conflict report strobe.
- conflict_id_i  in  ID_WIDTH  ID reported as already in use.
- id_valid_o  out  1  committed ID is valid.
- id_o  out  ID_WIDTH  committed node ID.
- busy_o  out  1  allocation in progress (REQ_RAND/ANNOUNCE/LISTEN).
- fail_o  out  1  retries exhausted.
- retry_count_o  out  $clog2(MAX_RETRY+1)  collision retries so far.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-handshake):
  - state goes to IDLE.
  - All outputs 0, candidate 0, timer 0, retry count 0.
  - Reset overrides every other input.
- All outputs are decoded from registered state and registers. No input-to-output combinational paths except handshake qualification.
- States: IDLE, REQ_RAND, ANNOUNCE, LISTEN, DONE, FAIL.
- IDLE: start_i=1 → REQ_RAND; retry count cleared.
- REQ_RAND: rand_ready_o=1.
  - On rand_valid_i, capture rand_id_i.
  - If the ID is reserved (ID_NONE=0 or ID_BROADCAST=all-ones), discard it and stay in REQ_RAND. The retry count does not change.
  - Otherwise → ANNOUNCE.
- ANNOUNCE: announce_valid_o=1, announce_id_o=candidate, both held stable until announce_ready_i.
  - On handshake → LISTEN, timer loaded with TIMEOUT_CYCLES-1.
- LISTEN: timer decrements each cycle, so the state lasts exactly TIMEOUT_CYCLES cycles. Timer at 0 with no conflict → DONE.
- Conflict match = conflict_valid_i && conflict_id_i==candidate, evaluated in ANNOUNCE and LISTEN.
  - On a match: if retry count==MAX_RETRY → FAIL; else retry count+1 → REQ_RAND.
  - A match in ANNOUNCE drops announce_valid_o the next cycle, even without a handshake.
  - Non-matching conflict reports are ignored.
- Simultaneous conflict match and timer expiry: conflict wins (retry path).
- DONE: id_valid_o=1, id_o=candidate, busy_o=0. start_i is ignored.
  - A conflict matching id_o → REQ_RAND, retry count cleared, id_valid_o=0 from the next cycle (re-allocation).
- FAIL: fail_o=1, stays until start_i=1 → REQ_RAND with retry count cleared, fail_o=0 next cycle.
- start_i is ignored while busy_o=1.
- Minimum latency, with valid and ready both high immediately:
  - start at cycle N.
  - REQ_RAND at N+1.
  - ANNOUNCE at N+2.
  - LISTEN at N+3 through N+2+TIMEOUT_CYCLES.
  - id_valid_o=1 from N+3+TIMEOUT_CYCLES.
- retry_count_o saturates at MAX_RETRY. It holds its value in DONE and FAIL until the next start or re-allocation.

Decomposition:
- types package gains:
  - node_id_t (logic [ID_WIDTH-1:0]).
  - ID_NONE and ID_BROADCAST constants.
  - alloc_state_e enum for the six states.
- One sub-module, listen_timer:
  - Loadable down-counter of width $clog2(TIMEOUT_CYCLES).
  - Ports: load, load value, enable, expired flag.
- FSM, candidate register and retry counter stay in node_id_allocator.

Test Plan:
- Basic: rst, start_i pulse, rand_id_i=8'h2A valid, announce_ready_i=1 → announce_id_o=8'h2A; id_valid_o=1 with id_o=8'h2A exactly 3+TIMEOUT_CYCLES cycles after start; retry_count_o=0.
- Reserved skip: rand_id_i sequence 8'h00, 8'hFF, 8'h11 → only 8'h11 announced; retry_count_o=0.
- Collision retry: candidate 8'h2A, conflict_id_i=8'h2A in LISTEN cycle 10 → REQ_RAND next cycle, retry_count_o=1; next candidate 8'h33 commits; conflict_id_i=8'h44 is ignored.
- Exhaustion: every candidate conflicted, MAX_RETRY=7 → after the 8th conflict fail_o=1, busy_o=0, retry_count_o=7; start_i restarts with fail_o=0.
- Edge timing: conflict on the final LISTEN cycle → retry, not DONE; announce_ready_i held low 5 cycles → announce_valid_o/announce_id_o stable; conflict on committed id_o in DONE → id_valid_o=0 next cycle, re-allocation.
- Reset mid-LISTEN: rst=1 for 1 cycle → all outputs 0, IDLE; a later start_i completes normally.

Source files
------------

// File: rtl/node_id_allocator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : node_id_allocator_pkg
//  Brief    : Shared types and constants for the node ID allocator.
//  Revision : 1.0  initial release
// ============================================================================
package node_id_allocator_pkg;

  // Node ID width used by the router header path
  localparam int NODE_ID_WIDTH = 8;

  typedef logic [NODE_ID_WIDTH-1:0] node_id_t;

  // Reserved IDs that may never be committed as a node address
  localparam node_id_t ID_NONE      = {NODE_ID_WIDTH{1'b0}};
  localparam node_id_t ID_BROADCAST = {NODE_ID_WIDTH{1'b1}};

  // Allocation state machine encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_RAND = 3'd1,
    ST_ANNOUNCE = 3'd2,
    ST_LISTEN   = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAIL     = 3'd5
  } alloc_state_e;

endpackage : node_id_allocator_pkg
`default_nettype wire

// File: rtl/node_id_allocator_listen_timer.sv
`default_nettype none
// ============================================================================
//  Module   : listen_timer
//  Brief    : Loadable down-counter timing the conflict listen window.
//             Stops at zero; expired_o is high while the count is zero.
//  Revision : 1.0  initial release
// ============================================================================
module listen_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load has priority, otherwise count down while enabled
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule : listen_timer
`default_nettype wire

// File: rtl/node_id_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : node_id_allocator
//  Brief    : Takes random candidate IDs, announces each one, listens for a
//             collision report over a fixed window and commits the ID when
//             nobody objects; retries a bounded number of times otherwise.
//  Revision : 1.0  initial release
// ============================================================================
module node_id_allocator
  import node_id_allocator_pkg::*;
#(
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic                             rand_valid_i,
  input  logic [ID_WIDTH-1:0]              rand_id_i,
  output logic                             rand_ready_o,
  output logic                             announce_valid_o,
  output logic [ID_WIDTH-1:0]              announce_id_o,
  input  logic                             announce_ready_i,
  input  logic                             conflict_valid_i,
  input  logic [ID_WIDTH-1:0]              conflict_id_i,
  output logic                             id_valid_o,
  output logic [ID_WIDTH-1:0]              id_o,
  output logic                             busy_o,
  output logic                             fail_o,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_count_o
);

  localparam int RC_W  = $clog2(MAX_RETRY + 1);
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRY);

  alloc_state_e        state_q, state_d;
  logic [ID_WIDTH-1:0] cand_q,  cand_d;
  logic [RC_W-1:0]     retry_q, retry_d;

  logic match;
  logic rand_reserved;
  logic timer_load;
  logic timer_en;
  logic timer_expired;

  // A report only matters if it names the ID we currently hold
  assign match         = conflict_valid_i && (conflict_id_i == cand_q);
  assign rand_reserved = (rand_id_i == {ID_WIDTH{1'b0}}) ||
                         (rand_id_i == {ID_WIDTH{1'b1}});

  // Window starts on the announce handshake; the final count of zero is the
  // last listen cycle, giving exactly TIMEOUT_CYCLES cycles in LISTEN
  assign timer_load = (state_q == ST_ANNOUNCE) && announce_ready_i;
  assign timer_en   = (state_q == ST_LISTEN);

  listen_timer #(
    .WIDTH (TMR_W)
  ) u_listen_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (TMR_LOAD),
    .en_i       (timer_en),
    .expired_o  (timer_expired)
  );

  // Next-state, candidate and retry-count logic
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    retry_d = retry_q;
    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (start_i) begin
          state_d = ST_REQ_RAND;
          retry_d = '0;
        end
      end
      ST_REQ_RAND: begin
        // Reserved candidates are dropped silently and cost no retry
        if (rand_valid_i && !rand_reserved) begin
          cand_d  = rand_id_i;
          state_d = ST_ANNOUNCE;
        end
      end
      ST_ANNOUNCE, ST_LISTEN: begin
        // A collision beats both the handshake and the window expiry
        if (match) begin
          if (retry_q == RC_MAX) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_REQ_RAND;
          end
        end else if ((state_q == ST_ANNOUNCE) && announce_ready_i) begin
          state_d = ST_LISTEN;
        end else if ((state_q == ST_LISTEN) && timer_expired) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Someone else claims our committed ID: start over from scratch
        if (match) begin
          state_d = ST_REQ_RAND;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, candidate and retry registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      retry_q <= retry_d;
    end
  end

  // Outputs are pure decodes of the registered state
  assign rand_ready_o     = (state_q == ST_REQ_RAND);
  assign announce_valid_o = (state_q == ST_ANNOUNCE);
  assign announce_id_o    = (state_q == ST_ANNOUNCE) ? cand_q : '0;
  assign id_valid_o       = (state_q == ST_DONE);
  assign id_o             = (state_q == ST_DONE) ? cand_q : '0;
  assign busy_o           = (state_q == ST_REQ_RAND) || (state_q == ST_ANNOUNCE) ||
                            (state_q == ST_LISTEN);
  assign fail_o           = (state_q == ST_FAIL);
  assign retry_count_o    = retry_q;

endmodule : node_id_allocator
`default_nettype wire
